ccd_scan_gen: RTL
=================

# ccd_scan_gen

Parametrised successor of the 2D CCD trigger generator for the OCT slave driver. On a start request, it latches a scan configuration and waits a programmable delay. It then emits a CCD exposure pulse train covering M lines of N points per frame, with a programmable pulse width, leading blank points, and an inter-line flyback gap. The CCD/camera pads sit downstream; it runs in single-frame or continuous mode and reports progress (line index, point index, line/frame strobes) to the scan controller.

## Interface
- CNT_W, 16, width of point/line/period/pulse/gap counters and config inputs
- DLY_W, 32, width of delay counter; must be >= 2*CNT_W
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level/pulse; sampled only in IDLE
- kill  in  1  abort request; sampled in every non-IDLE state
- continuous  in  1  1 = repeat frames until kill; 0 = single frame
- x_points  in  CNT_W  N, points per line
- x_skip  in  CNT_W  leading points per line with ccd suppressed
- y_lines  in  CNT_W  M, lines per frame
- cycles_per_point  in  CNT_W  P, clocks per point (0 treated as 1)
- pulse_cycles  in  CNT_W  W, ccd high clocks at start of each point
- gap_cycles  in  CNT_W  G, flyback clocks between lines
- delay_points  in  CNT_W  D, start delay in points
- ccd  out  1  exposure trigger
- line_sync  out  1  one-cycle strobe on first cycle of every line
- frame_done  out  1  one-cycle strobe on last cycle of every frame
- busy  out  1  high in any non-IDLE state
- aborted  out  1  one-cycle strobe when kill terminates a scan
- cfg_err  out  1  one-cycle strobe when start is rejected
- x_idx  out  CNT_W  current point index
- y_idx  out  CNT_W  current line index

## Operation
- Config latch: all config inputs and `continuous` are copied into shadow registers on the accepted start. Input changes mid-scan have no effect. P is latched as max(P,1).
- States: IDLE, DELAY, LINE, GAP.
- IDLE
  - start=1 with N==0 or M==0: stay in IDLE, pulse cfg_err.
  - Otherwise, latch config and zero all counters.
  - Go to DELAY if D*P != 0, else to LINE.
  - D*P is computed at full 2*CNT_W width; no truncation.
- DELAY: count D*P clocks, then enter LINE.
- LINE
  - A phase counter runs 0..P-1; at phase P-1 it wraps and x_idx increments.
  - After point N-1 at phase P-1:
    - Not the last line (y_idx < M-1): go to GAP if G>0, else directly to next line (LINE, y_idx+1, x_idx=0).
    - Last line: pulse frame_done that cycle. If continuous, start the next frame (y_idx=0) via GAP/LINE using the same rule; if not continuous, go to IDLE.
- GAP: count G clocks, then enter LINE with y_idx+1 (or 0 on frame wrap) and x_idx=0.
- ccd is high exactly in LINE cycles where phase < W and x_idx >= x_skip.
  - W >= P: ccd is high for the whole point.
  - W == 0: ccd never asserts.
  - x_skip >= N: the whole line is blank; timing and strobes are unchanged.
- line_sync is high on the LINE cycle with x_idx=0 and phase=0.
- kill in DELAY/LINE/GAP: next cycle IDLE; ccd and busy drop that same next cycle; aborted pulses; frame_done is not issued.
  - kill has priority over every same-cycle transition, including frame_done.
- start while busy is ignored. kill in IDLE is ignored.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, shadow registers 0. rst has priority over kill and start.
- All outputs are registered; no combinational path from inputs to outputs.
- Start sampled at edge k:
  - busy=1 from edge k+1.
  - First LINE cycle (line_sync=1) begins at edge k+1+D*P.
- With x_skip=0, W>0: the first ccd rising edge coincides with the first line_sync.
- Line period: N*P clocks. Line-to-line pitch: N*P+G clocks. Frame length: M*N*P + (M-1)*G clocks.
- Single mode: busy falls at the edge after the frame_done cycle.
- Continuous mode: the next frame's line_sync occurs G+1 clocks after the frame_done cycle.
- rst mid-scan: IDLE at the next edge, outputs 0, no aborted strobe.

## Test plan
- N=4, M=2, P=4, W=2, skip=0, G=0, D=0, single mode:
  - line_sync at edges k+1 and k+17.
  - ccd is 2 high/2 low ×8 points.
  - frame_done at k+32; busy low at k+33.
- D=3, P=5, skip=1, N=3, M=1: first line_sync at k+16; ccd absent for point 0, present for points 1–2.
- Continuous mode, N=2, M=2, P=2, G=3: frame_done every 14 clocks. Assert kill mid-gap: IDLE next cycle, aborted=1, ccd=0, no further strobes.
- Config changed mid-scan: waveform unchanged. Start with N=0: cfg_err=1, busy stays 0.
- Edge values:
  - P=0 behaves as P=1.
  - W=0 gives no ccd but correct strobes.
  - W>=P gives ccd solid across the line.
  - D=65535, P=65535 uses the full 32-bit delay with no wrap.
- rst asserted in LINE: all outputs 0 next cycle. A start during rst is ignored; a clean restart afterwards works.

Source files
------------

// File: rtl/ccd_scan_if.sv
// Scan request/config and progress/trigger signals between the scan controller
// (master) and the CCD trigger generator (slave).
interface ccd_scan_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             kill;
  logic             continuous;
  logic [CNT_W-1:0] x_points;
  logic [CNT_W-1:0] x_skip;
  logic [CNT_W-1:0] y_lines;
  logic [CNT_W-1:0] cycles_per_point;
  logic [CNT_W-1:0] pulse_cycles;
  logic [CNT_W-1:0] gap_cycles;
  logic [CNT_W-1:0] delay_points;
  logic             ccd;
  logic             line_sync;
  logic             frame_done;
  logic             busy;
  logic             aborted;
  logic             cfg_err;
  logic [CNT_W-1:0] x_idx;
  logic [CNT_W-1:0] y_idx;
  logic [1:0]       dbg_state;

  // Protocol: start is a level sampled only while idle (busy=0); an accepted
  // start is acknowledged by busy rising, a rejected one by a cfg_err strobe.
  // kill is a level honoured in any busy cycle and acknowledged by aborted.
  modport master (
    output start, kill, continuous, x_points, x_skip, y_lines,
           cycles_per_point, pulse_cycles, gap_cycles, delay_points,
    input  ccd, line_sync, frame_done, busy, aborted, cfg_err,
           x_idx, y_idx, dbg_state
  );

  modport slave (
    input  start, kill, continuous, x_points, x_skip, y_lines,
           cycles_per_point, pulse_cycles, gap_cycles, delay_points,
    output ccd, line_sync, frame_done, busy, aborted, cfg_err,
           x_idx, y_idx, dbg_state
  );
endinterface

// File: rtl/ccd_scan_gen.sv
// CCD exposure pulse-train generator: start delay, M lines of N points with
// per-point pulse width, leading blank points and flyback gaps between lines.
module ccd_scan_gen #(
  parameter int CNT_W = 16,
  parameter int DLY_W = 32
) (
  input logic      clk,
  input logic      rst,
  ccd_scan_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_LINE  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] n_sh, skip_sh, m_sh, p_sh, w_sh, g_sh;
  logic             cont_sh;
  logic [DLY_W-1:0] dly_total;

  logic [DLY_W-1:0] dly_cnt, dly_cnt_n;
  logic [CNT_W-1:0] phase, phase_n;
  logic [CNT_W-1:0] x_cnt, x_cnt_n;
  logic [CNT_W-1:0] y_cnt, y_cnt_n;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic             gap_wrap, gap_wrap_n;

  logic             ccd_q, line_sync_q, frame_done_q, busy_q, aborted_q, cfg_err_q;
  logic [CNT_W-1:0] x_idx_q, y_idx_q;

  logic [CNT_W-1:0] p_in;
  logic [DLY_W-1:0] dly_in;
  logic             cfg_ok, accept, reject, kill_act;
  logic             pt_last, x_last, y_last, frame_end;

  assign p_in   = (bus.cycles_per_point == '0) ? CNT_W'(1) : bus.cycles_per_point;
  // Operands widened first so the product keeps all 2*CNT_W bits.
  assign dly_in = DLY_W'(bus.delay_points) * DLY_W'(p_in);
  assign cfg_ok = (bus.x_points != '0) && (bus.y_lines != '0);
  assign accept = (state == S_IDLE) && bus.start && cfg_ok;
  assign reject = (state == S_IDLE) && bus.start && !cfg_ok;
  assign kill_act = (state != S_IDLE) && bus.kill;

  assign pt_last   = (phase == p_sh - CNT_W'(1));
  assign x_last    = (x_cnt == n_sh - CNT_W'(1));
  assign y_last    = (y_cnt == m_sh - CNT_W'(1));
  assign frame_end = (state == S_LINE) && pt_last && x_last && y_last;

  always_comb begin
    state_n    = state;
    dly_cnt_n  = dly_cnt;
    phase_n    = phase;
    x_cnt_n    = x_cnt;
    y_cnt_n    = y_cnt;
    gap_cnt_n  = gap_cnt;
    gap_wrap_n = gap_wrap;
    if (kill_act) begin
      state_n    = S_IDLE;
      dly_cnt_n  = '0;
      phase_n    = '0;
      x_cnt_n    = '0;
      y_cnt_n    = '0;
      gap_cnt_n  = '0;
      gap_wrap_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dly_cnt_n  = '0;
            phase_n    = '0;
            x_cnt_n    = '0;
            y_cnt_n    = '0;
            gap_cnt_n  = '0;
            gap_wrap_n = 1'b0;
            state_n    = (dly_in != '0) ? S_DELAY : S_LINE;
          end
        end
        S_DELAY: begin
          if (dly_cnt == dly_total - DLY_W'(1)) begin
            state_n   = S_LINE;
            dly_cnt_n = '0;
          end else begin
            dly_cnt_n = dly_cnt + DLY_W'(1);
          end
        end
        S_LINE: begin
          if (!pt_last) begin
            phase_n = phase + CNT_W'(1);
          end else begin
            phase_n = '0;
            if (!x_last) begin
              x_cnt_n = x_cnt + CNT_W'(1);
            end else begin
              x_cnt_n = '0;
              if (y_last && !cont_sh) begin
                state_n = S_IDLE;
                y_cnt_n = '0;
              end else if (g_sh != '0) begin
                // y_idx keeps the finished line through the flyback gap.
                state_n    = S_GAP;
                gap_cnt_n  = '0;
                gap_wrap_n = y_last;
              end else begin
                y_cnt_n = y_last ? '0 : y_cnt + CNT_W'(1);
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == g_sh - CNT_W'(1)) begin
            state_n   = S_LINE;
            gap_cnt_n = '0;
            y_cnt_n   = gap_wrap ? '0 : y_cnt + CNT_W'(1);
          end else begin
            gap_cnt_n = gap_cnt + CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dly_cnt      <= '0;
      phase        <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      gap_cnt      <= '0;
      gap_wrap     <= 1'b0;
      n_sh         <= '0;
      skip_sh      <= '0;
      m_sh         <= '0;
      p_sh         <= '0;
      w_sh         <= '0;
      g_sh         <= '0;
      cont_sh      <= 1'b0;
      dly_total    <= '0;
      ccd_q        <= 1'b0;
      line_sync_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      x_idx_q      <= '0;
      y_idx_q      <= '0;
    end else begin
      state    <= state_n;
      dly_cnt  <= dly_cnt_n;
      phase    <= phase_n;
      x_cnt    <= x_cnt_n;
      y_cnt    <= y_cnt_n;
      gap_cnt  <= gap_cnt_n;
      gap_wrap <= gap_wrap_n;
      if (accept) begin
        n_sh      <= bus.x_points;
        skip_sh   <= bus.x_skip;
        m_sh      <= bus.y_lines;
        p_sh      <= p_in;
        w_sh      <= bus.pulse_cycles;
        g_sh      <= bus.gap_cycles;
        cont_sh   <= bus.continuous;
        dly_total <= dly_in;
      end
      // Outputs show the cycle the counters describe; a kill blanks it instead.
      ccd_q        <= !kill_act && (state == S_LINE) && (phase < w_sh) && (x_cnt >= skip_sh);
      line_sync_q  <= !kill_act && (state == S_LINE) && (phase == '0) && (x_cnt == '0);
      frame_done_q <= !kill_act && frame_end;
      busy_q       <= !kill_act && (state != S_IDLE);
      aborted_q    <= kill_act;
      cfg_err_q    <= reject;
      x_idx_q      <= kill_act ? '0 : x_cnt;
      y_idx_q      <= kill_act ? '0 : y_cnt;
    end
  end

  assign bus.ccd        = ccd_q;
  assign bus.line_sync  = line_sync_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.aborted    = aborted_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.x_idx      = x_idx_q;
  assign bus.y_idx      = y_idx_q;
  assign bus.dbg_state  = state;

endmodule
